// File: rtl/pdm_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_decimator
//  Brief    : PDM clock generator, 1-bit sampler and 3rd-order CIC decimator
//             producing signed PCM samples with a one-cycle valid strobe.
//  Revision : 1.0
// ============================================================================

module pdm_decimator #(
    parameter int CLK_DIV  = 2,
    parameter int DEC_RATE = 64,
    parameter int LOG2_DEC = 6,
    parameter int O_BW     = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic            pdm_i,
    output logic            pdm_clk_o,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    output logic            sat_o
);

    localparam int c_width = 3*LOG2_DEC + 2;
    localparam int c_shift = 3*LOG2_DEC - 7;
    localparam int c_div_w = $clog2(CLK_DIV);

    localparam logic [c_div_w-1:0]        c_div_last    = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0]        c_half        = c_div_w'(CLK_DIV / 2);
    localparam logic [c_div_w-1:0]        c_strobe_at   = c_div_w'(CLK_DIV / 2 - 1);
    localparam logic [LOG2_DEC-1:0]       c_dec_last    = LOG2_DEC'(DEC_RATE - 1);
    localparam logic [1:0]                c_settle_done = 2'd3;
    localparam logic signed [c_width-1:0] c_plus_one    = c_width'(1);
    localparam logic signed [c_width-1:0] c_minus_one   = '1;
    localparam logic signed [c_width-1:0] c_out_max     = c_width'((2**(O_BW-1)) - 1);
    localparam logic signed [c_width-1:0] c_out_min     = ~c_out_max;

    // ------------------------------------------------------------------
    // Clock divider and sample strobe
    // ------------------------------------------------------------------
    logic               r_active;
    logic [c_div_w-1:0] r_div_cnt;
    logic               r_pdm_clk;
    logic [c_div_w-1:0] w_div_next;
    logic               w_strobe;

    // The first enabled edge only arms the divider, so the microphone sees a
    // full high phase before the first sample is taken.
    always_comb begin
        w_div_next = '0;
        if (r_active && (r_div_cnt != c_div_last)) begin
            w_div_next = r_div_cnt + c_div_w'(1);
        end
    end

    assign w_strobe = r_active && (r_div_cnt == c_strobe_at);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_active  <= 1'b0;
            r_div_cnt <= '0;
            r_pdm_clk <= 1'b0;
        end else if (!en_i) begin
            r_active  <= 1'b0;
            r_div_cnt <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            r_active  <= 1'b1;
            r_div_cnt <= w_div_next;
            r_pdm_clk <= (w_div_next < c_half);
        end
    end

    // ------------------------------------------------------------------
    // Integrators and decimation counter
    // ------------------------------------------------------------------
    logic signed [c_width-1:0] r_int1;
    logic signed [c_width-1:0] r_int2;
    logic signed [c_width-1:0] r_int3;
    logic signed [c_width-1:0] r_comb_in;
    logic [LOG2_DEC-1:0]       r_dec_cnt;
    logic                      r_tick;
    logic signed [c_width-1:0] w_x;
    logic signed [c_width-1:0] w_int1_next;
    logic signed [c_width-1:0] w_int2_next;
    logic signed [c_width-1:0] w_int3_next;
    logic                      w_frame_end;

    assign w_x         = pdm_i ? c_plus_one : c_minus_one;
    assign w_int1_next = r_int1 + w_x;
    assign w_int2_next = r_int2 + w_int1_next;
    assign w_int3_next = r_int3 + w_int2_next;
    assign w_frame_end = w_strobe && (r_dec_cnt == c_dec_last);

    // Wrap-around in the accumulators is harmless: the combs cancel it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_int1    <= '0;
            r_int2    <= '0;
            r_int3    <= '0;
            r_comb_in <= '0;
            r_dec_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (!en_i) begin
            r_int1    <= '0;
            r_int2    <= '0;
            r_int3    <= '0;
            r_comb_in <= '0;
            r_dec_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_frame_end;
            if (w_strobe) begin
                r_int1    <= w_int1_next;
                r_int2    <= w_int2_next;
                r_int3    <= w_int3_next;
                r_dec_cnt <= r_dec_cnt + LOG2_DEC'(1);
            end
            if (w_frame_end) begin
                r_comb_in <= w_int3_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb section, evaluated in the cycle following the decimate tick
    // ------------------------------------------------------------------
    logic signed [c_width-1:0] r_dly1;
    logic signed [c_width-1:0] r_dly2;
    logic signed [c_width-1:0] r_dly3;
    logic signed [c_width-1:0] w_c1;
    logic signed [c_width-1:0] w_c2;
    logic signed [c_width-1:0] w_c3;

    assign w_c1 = r_comb_in - r_dly1;
    assign w_c2 = w_c1 - r_dly2;
    assign w_c3 = w_c2 - r_dly3;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dly1 <= '0;
            r_dly2 <= '0;
            r_dly3 <= '0;
        end else if (!en_i) begin
            r_dly1 <= '0;
            r_dly2 <= '0;
            r_dly3 <= '0;
        end else if (r_tick) begin
            r_dly1 <= r_comb_in;
            r_dly2 <= w_c1;
            r_dly3 <= w_c2;
        end
    end

    // ------------------------------------------------------------------
    // Scaling, saturation, settle suppression and output registers
    // ------------------------------------------------------------------
    logic signed [c_width-1:0] w_scaled;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic [O_BW-1:0]           w_result;
    logic [1:0]                r_settle;
    logic [O_BW-1:0]           r_data;
    logic                      r_valid;
    logic                      r_sat;

    assign w_scaled = w_c3 >>> c_shift;
    assign w_sat_hi = (w_scaled > c_out_max);
    assign w_sat_lo = (w_scaled < c_out_min);

    always_comb begin
        w_result = w_scaled[O_BW-1:0];
        if (w_sat_hi) begin
            w_result = c_out_max[O_BW-1:0];
        end else if (w_sat_lo) begin
            w_result = c_out_min[O_BW-1:0];
        end
    end

    // The first three results carry the comb start-up transient and are
    // dropped; the counter then sticks at its terminal value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_settle <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_sat    <= 1'b0;
        end else if (!en_i) begin
            r_settle <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            if (r_tick) begin
                if (r_settle == c_settle_done) begin
                    r_data  <= w_result;
                    r_valid <= 1'b1;
                    r_sat   <= w_sat_hi || w_sat_lo;
                end else begin
                    r_settle <= r_settle + 2'd1;
                end
            end
        end
    end

    assign pdm_clk_o = r_pdm_clk;
    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign sat_o     = r_sat;

endmodule

`default_nettype wire
